// File: rtl/status_cond_unit_pkg.sv
// Shared constants for the NZCV status unit: condition codes, flag bit
// positions and widths.
package status_pkg;

    localparam int unsigned FLAG_W  = 4;
    localparam int unsigned COND_W  = 4;
    localparam int unsigned COUNT_W = 8;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [COND_W-1:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

endpackage

// File: rtl/status_cond_unit_if.sv
// EXE/ID side bus of the status unit; master drives the pipeline inputs.
interface status_cond_if;
    import status_pkg::*;

    logic [FLAG_W-1:0]  statusIn;
    logic               exeValid;
    logic               sUpdate;
    logic               freeze;
    logic               flush;
    logic [COND_W-1:0]  cond;
    logic [FLAG_W-1:0]  statusOut;
    logic               carryOut;
    logic               condPass;
    logic [COUNT_W-1:0] updCount;

    modport master (
        output statusIn, exeValid, sUpdate, freeze, flush, cond,
        input  statusOut, carryOut, condPass, updCount
    );

    modport slave (
        input  statusIn, exeValid, sUpdate, freeze, flush, cond,
        output statusOut, carryOut, condPass, updCount
    );

endinterface

// File: rtl/status_cond_unit_cond_eval.sv
// Combinational condition-code evaluator, shared with the ID stage.
module cond_eval
    import status_pkg::*;
(
    input  logic [COND_W-1:0] cond,
    input  logic [FLAG_W-1:0] flags,
    output logic              pass
);

    logic n, z, c, v;

    always_comb begin
        n    = flags[FLAG_N];
        z    = flags[FLAG_Z];
        c    = flags[FLAG_C];
        v    = flags[FLAG_V];
        pass = 1'b0;
        case (cond_e'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/status_cond_unit.sv
// Architectural NZCV register with EXE->ID flag bypass for condition
// evaluation and a debug count of committed flag updates.
module status_cond_unit
    import status_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    status_cond_if.slave bus
);

    logic [FLAG_W-1:0]  sr_q, sr_d;
    logic [COUNT_W-1:0] upd_count_q, upd_count_d;
    logic               commit_c;
    logic               bypass_c;
    logic [FLAG_W-1:0]  eff_flags_c;

    // Freeze stalls the commit but the ID stage still sees the in-flight flags.
    always_comb begin
        bypass_c    = bus.exeValid & bus.sUpdate & ~bus.flush;
        commit_c    = bypass_c & ~bus.freeze;
        eff_flags_c = bypass_c ? bus.statusIn : sr_q;
        sr_d        = sr_q;
        upd_count_d = upd_count_q;
        if (commit_c) begin
            sr_d        = bus.statusIn;
            upd_count_d = upd_count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q        <= '0;
            upd_count_q <= '0;
        end else begin
            sr_q        <= sr_d;
            upd_count_q <= upd_count_d;
        end
    end

    cond_eval u_cond_eval (
        .cond  (bus.cond),
        .flags (eff_flags_c),
        .pass  (bus.condPass)
    );

    assign bus.statusOut = sr_q;
    assign bus.carryOut  = sr_q[FLAG_C];
    assign bus.updCount  = upd_count_q;

endmodule
